// File: rtl/alu_acc_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_acc_seq
//  Purpose  : Parametrised accumulator ALU with valid/ready handshake,
//             carry/borrow and zero flags, and a shift-add multiplier that
//             takes WIDTH cycles per product.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_acc_seq #(
  parameter int WIDTH = 4,
  parameter int ACC_W = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             b_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [ACC_W-1:0] acc,
  output logic             carry,
  output logic             zero,
  output logic             done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] c_OP_INC = 3'b000;
  localparam logic [2:0] c_OP_ADD = 3'b001;
  localparam logic [2:0] c_OP_SUB = 3'b010;
  localparam logic [2:0] c_OP_PCK = 3'b011;
  localparam logic [2:0] c_OP_OR  = 3'b100;
  localparam logic [2:0] c_OP_SHL = 3'b101;
  localparam logic [2:0] c_OP_SHR = 3'b110;
  localparam logic [2:0] c_OP_MUL = 3'b111;

  // Count value seen on the final multiply step (count then reaches WIDTH).
  localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;
  logic [ACC_W-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [ACC_W-1:0] prod_q, prod_d;
  logic [CW-1:0]    count_q, count_d;

  logic [WIDTH-1:0] b_eff;
  logic [ACC_W-1:0] a_ext, b_ext;
  logic [ACC_W-1:0] alu_res;
  logic             alu_c;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] prod_step;
  logic [ACC_W-1:0] wr_val;
  logic             wr_c;
  logic             wr_en;

  // B operand source is resolved from the accumulator as it stands before the edge.
  assign b_eff = b_sel ? acc_q[WIDTH-1:0] : b;
  assign a_ext = ACC_W'(a);
  assign b_ext = ACC_W'(b_eff);

  // Single-cycle ALU result and carry for the currently presented op.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    sum     = '0;
    case (op)
      c_OP_INC: begin
        sum     = a_ext + ACC_W'(1);
        alu_res = sum;
        alu_c   = sum[WIDTH];
      end
      c_OP_ADD: begin
        sum     = a_ext + b_ext;
        alu_res = sum;
        alu_c   = sum[WIDTH];
      end
      c_OP_SUB: begin
        alu_res = a_ext - b_ext;
        alu_c   = (a < b_eff);
      end
      c_OP_PCK: alu_res = ACC_W'({a | b_eff, a ^ b_eff});
      c_OP_OR:  alu_res = a_ext | b_ext;
      c_OP_SHL: alu_res = (32'(a) >= ACC_W) ? '0 : (b_ext << a);
      c_OP_SHR: alu_res = (32'(a) >= ACC_W) ? '0 : (b_ext >> a);
      default:  alu_res = '0;
    endcase
  end

  // Next-state logic: accept in IDLE, iterate shift-add in MUL, write results.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    done_d    = 1'b0;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    count_d   = count_q;
    prod_step = prod_q;
    wr_val    = '0;
    wr_c      = 1'b0;
    wr_en     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (op == c_OP_MUL) begin
            mcand_d  = a_ext;
            mplier_d = b_eff;
            prod_d   = '0;
            count_d  = '0;
            state_d  = S_MUL;
          end else begin
            wr_en  = 1'b1;
            wr_val = alu_res;
            wr_c   = alu_c;
          end
        end
      end
      S_MUL: begin
        prod_step = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
        prod_d    = prod_step;
        mcand_d   = mcand_q << 1;
        mplier_d  = mplier_q >> 1;
        count_d   = count_q + CW'(1);
        if (count_q == c_LAST) begin
          wr_en   = 1'b1;
          wr_val  = prod_step;
          wr_c    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (wr_en) begin
      acc_d   = wr_val;
      carry_d = wr_c;
      zero_d  = (wr_val == '0);
      done_d  = 1'b1;
    end
  end

  // State and datapath registers; reset aborts any multiply in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      count_q  <= count_d;
    end
  end

  assign in_ready = (state_q == S_IDLE);
  assign busy     = (state_q == S_MUL);
  assign acc      = acc_q;
  assign carry    = carry_q;
  assign zero     = zero_q;
  assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_acc_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_acc_seq
//  Purpose  : Self-checking bench for alu_acc_seq (WIDTH=4, ACC_W=8) using a
//             cycle-level behavioural model plus literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_acc_seq;

  localparam int WIDTH = 4;
  localparam int ACC_W = 8;
  localparam int AMASK = (1 << ACC_W) - 1;
  localparam int WMASK = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       op = 3'd0;
  logic             b_sel = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [ACC_W-1:0] acc;
  logic             carry, zero, done, busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: the architectural view only (acc, flags, cycles left in a multiply).
  int m_acc = 0, m_carry = 0, m_zero = 1, m_done = 0, m_left = 0, m_pend = 0;
  int mA, mB, mRes, mC;

  alu_acc_seq #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .b_sel(b_sel), .a(a), .b(b), .acc(acc), .carry(carry),
    .zero(zero), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: advance on each rising edge, then compare the DUT just after it.
  always @(posedge clk) begin
    if (reset) begin
      m_acc = 0; m_carry = 0; m_zero = 1; m_done = 0; m_left = 0;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_acc = m_pend; m_carry = 0; m_zero = (m_pend == 0); m_done = 1;
        end
      end else if (in_valid) begin
        mA = int'(a);
        mB = b_sel ? (m_acc & WMASK) : int'(b);
        mC = 0;
        case (op)
          3'd0: begin mRes = mA + 1;  mC = (mRes >> WIDTH) & 1; end
          3'd1: begin mRes = mA + mB; mC = (mRes >> WIDTH) & 1; end
          3'd2: begin mRes = mA - mB; mC = (mA < mB) ? 1 : 0; end
          3'd3: mRes = ((mA | mB) << WIDTH) | (mA ^ mB);
          3'd4: mRes = mA | mB;
          3'd5: mRes = (mA >= ACC_W) ? 0 : (mB << mA);
          3'd6: mRes = (mA >= ACC_W) ? 0 : (mB >> mA);
          default: mRes = 0;
        endcase
        if (op == 3'd7) begin
          m_pend = (mA * mB) & AMASK;
          m_left = WIDTH;
        end else begin
          mRes   = mRes & AMASK;
          m_acc  = mRes; m_carry = mC; m_zero = (mRes == 0); m_done = 1;
        end
      end
    end
    #1;
    n_checks++;
    if (acc === ACC_W'(m_acc) && carry === m_carry[0] && zero === m_zero[0] &&
        done === m_done[0] && in_ready === (m_left == 0) && busy === (m_left > 0))
      n_pass++;
    else
      $display("FAIL model: acc=%h c=%b z=%b d=%b rdy=%b busy=%b expected acc=%h c=%0d z=%0d d=%0d left=%0d at %0t",
               acc, carry, zero, done, in_ready, busy, ACC_W'(m_acc), m_carry, m_zero, m_done, m_left, $time);
  end

  // Advance one clock; inputs change 2 time units after the edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic req(input logic [2:0] o, input int av, input int bv, input logic bs);
    in_valid = 1'b1; op = o; a = WIDTH'(av); b = WIDTH'(bv); b_sel = bs;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    reset = 1'b1; cyc(); cyc();
    reset = 1'b0;
    chk("rst_acc", int'(acc), 0);
    chk("rst_zero", int'(zero), 1);
    chk("rst_ready", int'(in_ready), 1);

    // Add with carry
    req(3'd1, 'hF, 'h3, 1'b0); cyc(); in_valid = 1'b0;
    chk("add_acc", int'(acc), 'h12);
    chk("add_carry", int'(carry), 1);
    chk("add_done", int'(done), 1);
    cyc();
    chk("add_done_drop", int'(done), 0);

    // Accumulate chain from 0x05
    req(3'd1, 'h5, 'h0, 1'b0); cyc();
    chk("acc_seed", int'(acc), 'h05);
    req(3'd1, 'h2, 'h0, 1'b1); cyc();
    chk("chain1", int'(acc), 'h07);
    cyc();
    chk("chain2", int'(acc), 'h09);
    cyc();
    chk("chain3", int'(acc), 'h0B);
    chk("chain_done", int'(done), 1);
    in_valid = 1'b0;

    // Subtract with borrow, then equal operands
    req(3'd2, 'h3, 'h5, 1'b0); cyc();
    chk("sub_acc", int'(acc), 'hFE);
    chk("sub_borrow", int'(carry), 1);
    req(3'd2, 'h5, 'h5, 1'b0); cyc(); in_valid = 1'b0;
    chk("sub0_acc", int'(acc), 0);
    chk("sub0_zero", int'(zero), 1);
    chk("sub0_carry", int'(carry), 0);

    // Multiply 0xF * 0xD with a request held during MUL that must be ignored
    req(3'd7, 'hF, 'hD, 1'b0); cyc();
    req(3'd1, 'h1, 'h1, 1'b0);
    chk("mul_busy0", int'(busy), 1);
    chk("mul_ready0", int'(in_ready), 0);
    for (int i = 1; i < WIDTH; i++) begin
      cyc();
      chk("mul_busy", int'(busy), 1);
      chk("mul_hold", int'(acc), 0);
    end
    cyc(); in_valid = 1'b0;
    chk("mul_acc", int'(acc), 'hC3);
    chk("mul_done", int'(done), 1);
    chk("mul_ready", int'(in_ready), 1);
    cyc();
    chk("mul_done_once", int'(done), 0);
    chk("mul_keep", int'(acc), 'hC3);

    // Shifts
    req(3'd5, 'h3, 'h9, 1'b0); cyc();
    chk("shl", int'(acc), 'h48);
    req(3'd6, 'h2, 'hC, 1'b0); cyc();
    chk("shr", int'(acc), 'h03);
    req(3'd5, 'h9, 'hF, 1'b0); cyc(); in_valid = 1'b0;
    chk("shl_over", int'(acc), 0);
    chk("shl_over_zero", int'(zero), 1);

    // Randomised traffic, with occasional resets
    for (int i = 0; i < 600; i++) begin
      reset    = ($urandom_range(0, 60) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      op       = 3'($urandom_range(0, 7));
      a        = WIDTH'($urandom);
      b        = WIDTH'($urandom);
      b_sel    = 1'($urandom);
      cyc();
    end
    reset = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < WIDTH + 1; i++) cyc();

    // Reset in the middle of a multiply
    req(3'd7, 'h7, 'h6, 1'b0); cyc(); in_valid = 1'b0;
    cyc();
    reset = 1'b1; cyc(); cyc();
    reset = 1'b0;
    chk("mrst_acc", int'(acc), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_carry", int'(carry), 0);
    chk("mrst_done", int'(done), 0);
    for (int i = 0; i < WIDTH; i++) begin
      cyc();
      chk("mrst_nodone", int'(done), 0);
    end
    chk("mrst_acc_after", int'(acc), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_acc_seq.md
Name: alu_acc_seq

Overview:
- Parametrised accumulator ALU, the successor to the board-level 4-bit ALU/register pair.
- Operand A is WIDTH bits. Operand B comes from a port or from the low half of the accumulator.
- The result is written to an ACC_W-bit accumulator register.
- Adds a valid/ready handshake, a subtract op, carry/borrow and zero flags, and a multi-cycle shift-add multiplier in place of a combinational multiply.
- Sits between switch/key input logic and the seven-segment/LED display drivers.

Parameters:
- WIDTH, 4, operand width in bits (2..16).
- ACC_W, 2*WIDTH, accumulator/result width; must be >= WIDTH+1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  request: operands and op are valid this cycle
- in_ready  out  1  block can accept a request; equals (state==IDLE)
- op  in  3  operation select (see Behaviour)
- b_sel  in  1  0: B = b port; 1: B = acc[WIDTH-1:0]
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B (port source)
- acc  out  ACC_W  accumulator register
- carry  out  1  carry/borrow flag of last completed op
- zero  out  1  1 when last written acc value == 0
- done  out  1  one-cycle pulse: acc/flags updated
- busy  out  1  multiply in progress (state==MUL)

Behaviour:
- Reset (sampled on posedge clk while reset=1): acc=0, carry=0, zero=1, done=0, state=IDLE, multiplier registers and count=0.
- Reset has priority over every other event. Reset mid-multiply aborts the operation; acc is not written; no done pulse.
- Accept: on a posedge with in_valid & in_ready, op/a/B are captured. B is resolved from b_sel using the acc value before that edge. in_valid while in_ready=0 is ignored and is not queued.
- Ops (A, B zero-extended to ACC_W; results truncated to ACC_W):
  - 000: A+1; carry = bit WIDTH of the sum.
  - 001: A+B; carry = bit WIDTH of the sum.
  - 010: A-B as an ACC_W two's-complement result; carry = borrow (A<B).
  - 011: {A|B, A^B} in the low 2*WIDTH bits; carry=0.
  - 100: A|B; carry=0.
  - 101: B<<A; if A>=ACC_W, result=0; carry=0.
  - 110: B>>A, logical; if A>=ACC_W, result=0; carry=0.
  - 111: A*B, multi-cycle; carry=0.
- Single-cycle ops (000-110):
  - acc, carry and zero are written at the accept edge.
  - done=1 for exactly the following cycle.
  - State stays IDLE, so back-to-back accepts every cycle are legal; done stays high across consecutive accepts.
- Multiply (111), states IDLE -> MUL -> IDLE:
  - At the accept edge: mcand=A (ACC_W bits), mplier=B, prod=0, count=0; state goes to MUL; busy=1 and in_ready=0 from the next cycle.
  - Each MUL edge: if mplier[0], prod += mcand; then mcand <<= 1, mplier >>= 1, count++.
  - On the edge where count reaches WIDTH: acc=final prod, flags update, state=IDLE.
  - Timing: accept at edge N, acc written at edge N+WIDTH. done=1 and in_ready=1 in the cycle after edge N+WIDTH.
- acc is held unchanged in every cycle without a write. No early termination: the multiply always takes WIDTH cycles, including when B=0.
- zero is recomputed from the new acc on every write.

Test Plan (WIDTH=4, ACC_W=8):
- Reset: hold reset 2 cycles after random ops, including mid-multiply -> acc=0x00, zero=1, carry=0, done=0, in_ready=1, busy=0.
- Add with carry: op=001, a=0xF, b=0x3, b_sel=0 -> next cycle acc=0x12, carry=1, zero=0, done=1 for one cycle.
- Accumulate chain: acc=0x05, then op=001, a=0x2, b_sel=1 on 3 consecutive cycles -> acc sequence 0x07, 0x09, 0x0B; done held high 3 cycles.
- Subtract/borrow: op=010, a=0x3, b=0x5 -> acc=0xFE, carry=1. Then a=0x5, b=0x5 -> acc=0x00, zero=1, carry=0.
- Multiply: op=111, a=0xF, b=0xD accepted at edge N -> busy=1, in_ready=0 for 4 cycles; a second in_valid during MUL is ignored; acc=0xC3 written at edge N+4; done pulses once.
- Shifts: op=101, a=0x3, b=0x9 -> acc=0x48. op=110, a=0x2, b=0xC -> acc=0x03. op=101, a=0x9, b=0xF -> acc=0x00, zero=1.
